// File: rtl/rename_stage_n.sv
// rename_stage_n: N-wide register rename (RAT lookup, intra-group bypass, circular free list, retire release).
// Define RENAME_FLUSH_EN to add flush recovery from a committed RAT.
module rename_stage_n #(
  parameter int unsigned ARF_WIDTH  = 5,
  parameter int unsigned PRF_WIDTH  = 6,
  parameter int unsigned DECODE_NUM = 4,
  parameter int unsigned RETIRE_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DECODE_NUM*ARF_WIDTH-1:0]  rs1,
  input  logic [DECODE_NUM*ARF_WIDTH-1:0]  rs2,
  input  logic [DECODE_NUM*ARF_WIDTH-1:0]  rd,
  input  logic [DECODE_NUM-1:0]            prs1_v,
  input  logic [DECODE_NUM-1:0]            prs2_v,
  input  logic [DECODE_NUM-1:0]            prd_v,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DECODE_NUM*PRF_WIDTH-1:0]  prs1,
  output logic [DECODE_NUM*PRF_WIDTH-1:0]  prs2,
  output logic [DECODE_NUM*PRF_WIDTH-1:0]  prd,
  output logic [DECODE_NUM*PRF_WIDTH-1:0]  preprd,
  input  logic [RETIRE_NUM-1:0]            retire,
  input  logic [RETIRE_NUM-1:0]            rob_areg_v,
  input  logic [RETIRE_NUM*PRF_WIDTH-1:0]  rob_opreg,
`ifdef RENAME_FLUSH_EN
  input  logic                             flush,
  input  logic [RETIRE_NUM*ARF_WIDTH-1:0]  rob_areg,
  input  logic [RETIRE_NUM*PRF_WIDTH-1:0]  rob_prd,
`endif
  output logic [PRF_WIDTH:0]               free_cnt
);

  localparam int unsigned ARF_NUM = 1 << ARF_WIDTH;
  localparam int unsigned PRF_NUM = 1 << PRF_WIDTH;
  localparam int unsigned DEPTH   = PRF_NUM - ARF_NUM;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PRF_WIDTH + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef logic [PRF_WIDTH-1:0] preg_t;
  typedef logic [ARF_WIDTH-1:0] areg_t;
  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  preg_t rat   [ARF_NUM];
  preg_t rat_n [ARF_NUM];
  preg_t fl    [DEPTH];
  ptr_t  head, tail, head_n, tail_n;
  cnt_t  cnt_n, need, nfree;
  logic  fire;

  logic [DECODE_NUM-1:0]           alloc;
  preg_t                           new_prd [DECODE_NUM];
  logic [DECODE_NUM*PRF_WIDTH-1:0] prs1_c, prs2_c, prd_c, preprd_c;
  logic [RETIRE_NUM-1:0]           free_en;
  ptr_t                            free_idx [RETIRE_NUM];

`ifdef RENAME_FLUSH_EN
  preg_t crat   [ARF_NUM];
  preg_t crat_n [ARF_NUM];
  cnt_t  inflight, inflight_n, nret;
`endif

  function automatic ptr_t wrap_add(input ptr_t p, input cnt_t k);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(k);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return PTR_W'(s);
  endfunction

`ifdef RENAME_FLUSH_EN
  function automatic ptr_t wrap_sub(input ptr_t p, input cnt_t k);
    logic [SUM_W-1:0] s;
    if (SUM_W'(k) > SUM_W'(p)) s = SUM_W'(p) + SUM_W'(DEPTH) - SUM_W'(k);
    else                       s = SUM_W'(p) - SUM_W'(k);
    return PTR_W'(s);
  endfunction
`endif

  // k-th allocating slot in slot order takes free-list entry head+k
  always_comb begin
    need  = '0;
    alloc = '0;
    for (int i = 0; i < int'(DECODE_NUM); i++) begin
      new_prd[i] = '0;
      alloc[i]   = prd_v[i] && (rd[i*ARF_WIDTH +: ARF_WIDTH] != '0);
      if (alloc[i]) begin
        new_prd[i] = fl[wrap_add(head, need)];
        need       = need + cnt_t'(1);
      end
    end
  end

  // Sources and previous dest: youngest older writer in the group overrides the RAT
  always_comb begin
    areg_t r1, r2, rdi, rdj;
    preg_t v1, v2, vd;
    prs1_c   = '0;
    prs2_c   = '0;
    prd_c    = '0;
    preprd_c = '0;
    for (int i = 0; i < int'(DECODE_NUM); i++) begin
      r1  = rs1[i*ARF_WIDTH +: ARF_WIDTH];
      r2  = rs2[i*ARF_WIDTH +: ARF_WIDTH];
      rdi = rd[i*ARF_WIDTH +: ARF_WIDTH];
      v1  = rat[r1];
      v2  = rat[r2];
      vd  = rat[rdi];
      for (int j = 0; j < int'(DECODE_NUM); j++) begin
        rdj = rd[j*ARF_WIDTH +: ARF_WIDTH];
        if (j < i && alloc[j]) begin
          if (rdj == r1)  v1 = new_prd[j];
          if (rdj == r2)  v2 = new_prd[j];
          if (rdj == rdi) vd = new_prd[j];
        end
      end
      prs1_c[i*PRF_WIDTH +: PRF_WIDTH]   = (prs1_v[i] && r1 != '0) ? v1 : '0;
      prs2_c[i*PRF_WIDTH +: PRF_WIDTH]   = (prs2_v[i] && r2 != '0) ? v2 : '0;
      prd_c[i*PRF_WIDTH +: PRF_WIDTH]    = new_prd[i];
      preprd_c[i*PRF_WIDTH +: PRF_WIDTH] = alloc[i] ? vd : '0;
    end
  end

  // Released regs are appended at the tail in slot order; P0 is never released
  always_comb begin
    nfree   = '0;
    free_en = '0;
    for (int i = 0; i < int'(RETIRE_NUM); i++) begin
      free_idx[i] = '0;
      if (retire[i] && rob_areg_v[i] && rob_opreg[i*PRF_WIDTH +: PRF_WIDTH] != '0) begin
        free_en[i]  = 1'b1;
        free_idx[i] = wrap_add(tail, nfree);
        nfree       = nfree + cnt_t'(1);
      end
    end
  end

  always_comb begin
    in_ready = (free_cnt >= need) && (!out_valid || out_ready);
`ifdef RENAME_FLUSH_EN
    if (flush) in_ready = 1'b0;
`endif
  end

  assign fire = in_valid && in_ready;

  always_comb begin
    rat_n = rat;
    if (fire) begin
      for (int i = 0; i < int'(DECODE_NUM); i++)
        if (alloc[i]) rat_n[rd[i*ARF_WIDTH +: ARF_WIDTH]] = new_prd[i];
    end
    head_n = fire ? wrap_add(head, need) : head;
    tail_n = wrap_add(tail, nfree);
    cnt_n  = free_cnt - (fire ? need : '0) + nfree;
`ifdef RENAME_FLUSH_EN
    crat_n = crat;
    nret   = '0;
    for (int i = 0; i < int'(RETIRE_NUM); i++) begin
      if (retire[i] && rob_areg_v[i]) begin
        nret = nret + cnt_t'(1);
        if (rob_areg[i*ARF_WIDTH +: ARF_WIDTH] != '0)
          crat_n[rob_areg[i*ARF_WIDTH +: ARF_WIDTH]] = rob_prd[i*PRF_WIDTH +: PRF_WIDTH];
      end
    end
    inflight_n = inflight + (fire ? need : '0) - nret;
    // Uncommitted allocations sit just behind head; rewind over them
    if (flush) begin
      rat_n      = crat_n;
      head_n     = wrap_sub(head, inflight_n);
      cnt_n      = cnt_n + inflight_n;
      inflight_n = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < int'(ARF_NUM); r++) rat[r] <= preg_t'(r);
      for (int i = 0; i < int'(DEPTH); i++)   fl[i]  <= preg_t'(ARF_NUM + i);
      head      <= '0;
      tail      <= '0;
      free_cnt  <= cnt_t'(DEPTH);
      out_valid <= 1'b0;
      prs1      <= '0;
      prs2      <= '0;
      prd       <= '0;
      preprd    <= '0;
`ifdef RENAME_FLUSH_EN
      for (int r = 0; r < int'(ARF_NUM); r++) crat[r] <= preg_t'(r);
      inflight <= '0;
`endif
    end else begin
      rat      <= rat_n;
      head     <= head_n;
      tail     <= tail_n;
      free_cnt <= cnt_n;
      for (int i = 0; i < int'(RETIRE_NUM); i++)
        if (free_en[i]) fl[free_idx[i]] <= rob_opreg[i*PRF_WIDTH +: PRF_WIDTH];
      if (fire) begin
        out_valid <= 1'b1;
        prs1      <= prs1_c;
        prs2      <= prs2_c;
        prd       <= prd_c;
        preprd    <= preprd_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef RENAME_FLUSH_EN
      crat     <= crat_n;
      inflight <= inflight_n;
      if (flush) out_valid <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (SUM_W'(free_cnt) + SUM_W'(nfree) <= SUM_W'(DEPTH))
        else $error("rename_stage_n: free list overflow");
    end
  end

endmodule

// File: tb/tb_rename_stage_n.sv
// tb_rename_stage_n: directed + random stimulus against a queue-based rename model.
// Flush scenario runs only when RENAME_FLUSH_EN is defined.
module tb_rename_stage_n;
  localparam int AW = 5, PW = 6, DN = 4, RN = 4;
  localparam int ANUM = 32, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [DN*AW-1:0] rs1, rs2, rd;
  logic [DN-1:0] prs1_v, prs2_v, prd_v;
  logic [DN*PW-1:0] prs1, prs2, prd, preprd;
  logic [RN-1:0] retire, rob_areg_v;
  logic [RN*PW-1:0] rob_opreg;
  logic [PW:0] free_cnt;
`ifdef RENAME_FLUSH_EN
  logic flush;
  logic [RN*AW-1:0] rob_areg;
  logic [RN*PW-1:0] rob_prd;
`endif

  rename_stage_n dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .prs1_v(prs1_v), .prs2_v(prs2_v), .prd_v(prd_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .prs1(prs1), .prs2(prs2), .prd(prd), .preprd(preprd),
    .retire(retire), .rob_areg_v(rob_areg_v), .rob_opreg(rob_opreg),
`ifdef RENAME_FLUSH_EN
    .flush(flush), .rob_areg(rob_areg), .rob_prd(rob_prd),
`endif
    .free_cnt(free_cnt)
  );

  typedef struct {int areg; int prd; int old;} rob_t;

  int mrat[ANUM];
  int mcrat[ANUM];
  int mq[$];
  rob_t pend[$];
  rob_t cur_ret[$];
  logic [DN*PW-1:0] e_prs1, e_prs2, e_prd, e_pre;
  logic e_ov;
  int head_m;
  int checks = 0, errors = 0;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input int r1, input int r2, input int d,
                          input bit v1, input bit v2, input bit vd);
    rs1[i*AW +: AW] = AW'(r1);
    rs2[i*AW +: AW] = AW'(r2);
    rd[i*AW +: AW]  = AW'(d);
    prs1_v[i] = v1;
    prs2_v[i] = v2;
    prd_v[i]  = vd;
  endtask

  // Random group with at most max_need allocating slots
  task automatic rand_group(input int max_need);
    int n, d;
    bit vd;
    n = 0;
    for (int i = 0; i < DN; i++) begin
      d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 11));
      vd = ($urandom_range(0, 3) != 0);
      if (vd && d != 0) begin
        if (n >= max_need) vd = 1'b0;
        else n++;
      end
      set_slot(i, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), d,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, vd);
    end
  endtask

  // Group whose first n slots allocate
  task automatic fixed_group(input int n);
    for (int i = 0; i < DN; i++)
      set_slot(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               (i < n) ? int'($urandom_range(1, 31)) : 0, 1'b1, 1'b1, i < n);
  endtask

  // Retire up to n oldest renamed instructions, scattered over the retire slots
  task automatic set_retire(input int n);
    int left;
    rob_t e;
    left = min2(n, pend.size());
    retire     = '0;
    rob_areg_v = RN'($urandom);
    rob_opreg  = (RN*PW)'($urandom);
`ifdef RENAME_FLUSH_EN
    rob_areg = (RN*AW)'($urandom);
    rob_prd  = (RN*PW)'($urandom);
`endif
    for (int i = 0; i < RN; i++) begin
      if (left > 0 && ($urandom_range(0, 1) == 1 || (RN - i) <= left)) begin
        e = pend.pop_front();
        cur_ret.push_back(e);
        retire[i] = 1'b1;
        rob_areg_v[i] = 1'b1;
        rob_opreg[i*PW +: PW] = PW'(e.old);
`ifdef RENAME_FLUSH_EN
        rob_areg[i*AW +: AW] = AW'(e.areg);
        rob_prd[i*PW +: PW]  = PW'(e.prd);
`endif
        left--;
      end
    end
  endtask

  // One clock: predict in_ready, apply the cycle to the model, check registered results
  task automatic cycle();
    int need, k, p, pre, d, r;
    bit rdy, fire;
    int wrat[ANUM];
    #1;
    need = 0;
    for (int i = 0; i < DN; i++)
      if (prd_v[i] && rd[i*AW +: AW] != '0) need++;
    rdy = (mq.size() >= need) && (!e_ov || out_ready);
`ifdef RENAME_FLUSH_EN
    if (flush) rdy = 1'b0;
`endif
    chk("in_ready", in_ready, rdy);
    fire = in_valid && rdy;
    if (fire) begin
      wrat = mrat;
      k = 0;
      for (int i = 0; i < DN; i++) begin
        r = int'(rs1[i*AW +: AW]);
        e_prs1[i*PW +: PW] = (prs1_v[i] && r != 0) ? PW'(wrat[r]) : '0;
        r = int'(rs2[i*AW +: AW]);
        e_prs2[i*PW +: PW] = (prs2_v[i] && r != 0) ? PW'(wrat[r]) : '0;
        d = int'(rd[i*AW +: AW]);
        if (prd_v[i] && d != 0) begin
          p = mq[k];
          k++;
          pre = wrat[d];
          wrat[d] = p;
          pend.push_back('{d, p, pre});
        end else begin
          p = 0;
          pre = 0;
        end
        e_prd[i*PW +: PW] = PW'(p);
        e_pre[i*PW +: PW] = PW'(pre);
      end
      for (int i = 0; i < k; i++) void'(mq.pop_front());
      mrat = wrat;
      e_ov = 1'b1;
      head_m = (head_m + need) % DEPTH;
    end else if (out_ready) begin
      e_ov = 1'b0;
    end
    foreach (cur_ret[n]) begin
      if (cur_ret[n].old != 0) mq.push_back(cur_ret[n].old);
      if (cur_ret[n].areg != 0) mcrat[cur_ret[n].areg] = cur_ret[n].prd;
    end
`ifdef RENAME_FLUSH_EN
    if (flush) begin
      mrat = mcrat;
      head_m = (head_m - pend.size() + DEPTH) % DEPTH;
      for (int n = pend.size() - 1; n >= 0; n--) mq.push_front(pend[n].prd);
      pend.delete();
      e_ov = 1'b0;
    end
`endif
    cur_ret.delete();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, e_ov);
    chk("free_cnt", free_cnt, mq.size());
    chk("prs1", prs1, e_prs1);
    chk("prs2", prs2, e_prs2);
    chk("prd", prd, e_prd);
    chk("preprd", preprd, e_pre);
    @(negedge clk);
  endtask

  initial begin
    int n, g, cnt_before, first_unret;
    int wexp[4];
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0;
    prs1_v = '0; prs2_v = '0; prd_v = '0;
    retire = '0; rob_areg_v = '0; rob_opreg = '0;
`ifdef RENAME_FLUSH_EN
    flush = 1'b0; rob_areg = '0; rob_prd = '0;
`endif
    for (int r = 0; r < ANUM; r++) begin
      mrat[r] = r;
      mcrat[r] = r;
    end
    for (int i = 0; i < DEPTH; i++) mq.push_back(ANUM + i);
    e_prs1 = '0; e_prs2 = '0; e_prd = '0; e_pre = '0;
    e_ov = 1'b0;
    head_m = 0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_free_cnt", free_cnt, 32);
    chk("rst_prd", prd, 0);
    chk("rst_preprd", preprd, 0);
    rst = 1'b1;

    // Group A: rd=1..4, rs1=0
    for (int i = 0; i < DN; i++) set_slot(i, 0, 0, i + 1, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    set_retire(0);
    cycle();
    chk("A_prd", prd, {6'd35, 6'd34, 6'd33, 6'd32});
    chk("A_preprd", preprd, {6'd4, 6'd3, 6'd2, 6'd1});
    chk("A_prs1", prs1, 0);
    chk("A_free", free_cnt, 28);

    // Group B: RAW/WAW inside the group
    set_slot(0, 1, 2, 7, 1'b1, 1'b1, 1'b1);
    set_slot(1, 3, 7, 7, 1'b1, 1'b1, 1'b1);
    set_slot(2, 4, 6, 5, 1'b1, 1'b1, 1'b1);
    set_slot(3, 8, 9, 7, 1'b1, 1'b1, 1'b1);
    cycle();
    chk("B_s1_prs2", prs2[PW +: PW], 36);
    chk("B_s1_preprd", preprd[PW +: PW], 36);
    chk("B_s3_preprd", preprd[3*PW +: PW], 37);
    chk("B_s0_preprd", preprd[0 +: PW], 7);

    // Group C: read back RAT[7] and RAT[5]
    for (int i = 0; i < DN; i++) set_slot(i, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    set_slot(0, 7, 5, 0, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("C_rat7", prs1[0 +: PW], 39);
    chk("C_rat5", prs2[0 +: PW], 38);

    // Random traffic with backpressure and retirement
    repeat (300) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_group(DN);
      set_retire(int'($urandom_range(0, RN)));
      cycle();
    end

    // Drain free list to 2, then offer need=3 while one reg is released
    in_valid = 1'b1;
    out_ready = 1'b1;
    g = 0;
    while (mq.size() > 2 && g < 100) begin
      set_retire(0);
      fixed_group(min2(4, mq.size() - 2));
      cycle();
      g++;
    end
    chk("drain_cnt", free_cnt, 2);
    fixed_group(3);
    set_retire(1);
    cycle();
    chk("drain_refill", free_cnt, 3);
    set_retire(0);
    cycle();
    chk("drain_alloc", free_cnt, 0);

    // Stall: out_ready low for two cycles with a pending group
    in_valid = 1'b0;
    set_retire(RN); cycle();
    set_retire(RN); cycle();
    in_valid = 1'b1;
    fixed_group(1);
    set_retire(0);
    cycle();
    cnt_before = mq.size();
    out_ready = 1'b0;
    fixed_group(2);
    repeat (2) cycle();
    chk("stall_cnt", free_cnt, cnt_before);
    chk("stall_valid", out_valid, 1);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("stall_once_cnt", free_cnt, cnt_before - 2);

    // Bring head to depth-2, then allocate 4 across the wrap point
    g = 0;
    while (head_m != DEPTH - 2 && g < 200) begin
      in_valid = 1'b1;
      set_retire(RN);
      fixed_group(min2(min2((DEPTH - 2 - head_m + DEPTH) % DEPTH, 4), mq.size()));
      cycle();
      g++;
    end
    g = 0;
    while (mq.size() < 4 && g < 50) begin
      in_valid = 1'b0;
      set_retire(RN);
      cycle();
      g++;
    end
    chk("wrap_head_reached", (head_m == DEPTH - 2 && mq.size() >= 4), 1);
    for (int i = 0; i < 4; i++) wexp[i] = mq[i];
    in_valid = 1'b1;
    fixed_group(4);
    set_retire(0);
    cycle();
    for (int i = 0; i < 4; i++) chk("wrap_prd", prd[i*PW +: PW], wexp[i]);

`ifdef RENAME_FLUSH_EN
    // Flush: rename 8 dests, retire 3, flush returns the other 5
    in_valid = 1'b0;
    g = 0;
    while (pend.size() > 0 && g < 50) begin
      set_retire(RN);
      cycle();
      g++;
    end
    chk("fl_idle_cnt", free_cnt, DEPTH);
    in_valid = 1'b1;
    set_retire(0);
    fixed_group(4); cycle();
    fixed_group(4); cycle();
    in_valid = 1'b0;
    set_retire(3);
    cycle();
    cnt_before = mq.size();
    first_unret = pend[0].prd;
    flush = 1'b1;
    set_retire(0);
    cycle();
    flush = 1'b0;
    chk("fl_cnt", free_cnt, cnt_before + 5);
    chk("fl_out_valid", out_valid, 0);
    in_valid = 1'b1;
    fixed_group(1);
    cycle();
    chk("fl_next_prd", prd[0 +: PW], first_unret);
    repeat (20) begin
      rand_group(DN);
      set_retire(int'($urandom_range(0, RN)));
      cycle();
    end
`endif

    in_valid = 1'b0;
    set_retire(0);
    repeat (2) cycle();
    n = checks;
    $display("Simulation finished: %0d checks, %0d errors", n, errors);
    $finish;
  end

endmodule
